restoring_divider_4bit: RTL and testbench

- Sequential unsigned restoring divider: N-bit dividend ÷ N-bit divisor → N-bit quotient and N-bit remainder, one quotient bit per clock.
- Inverse-direction companion to the registered 4-bit carry-lookahead adder datapath.
- Each trial subtraction is performed as an add: ones-complement of the divisor plus carry-in 1.
- Operands are captured on a start pulse; a start/busy/done handshake sequences the operation; results are held in output registers until the next completed operation.

---
 rtl/restoring_divider_4bit.sv | 113 +++++++++++
 tb/tb_restoring_divider_4bit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_4bit.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional DIVZERO_DETECT_EN: zero divisor short-circuits straight to DONE.
module restoring_divider_4bit #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [N-1:0]  w_q;
    logic [N:0]    w_r;
    logic [N-1:0]  d;
    logic [CW-1:0] cnt;

    logic [N:0]    s;
    logic [N+1:0]  sum;
    logic          c;
    logic [N-1:0]  nq;
    logic [N:0]    nr;

    // Trial subtraction as S + ~D + 1; carry-out set means S >= D
    always_comb begin
        s   = {w_r[N-1:0], w_q[N-1]};
        sum = {1'b0, s} + {1'b0, ~{1'b0, d}} + {{(N+1){1'b0}}, 1'b1};
        c   = sum[N+1];
        nq  = {w_q[N-2:0], c};
        nr  = c ? sum[N:0] : s;
    end

`ifdef DIVZERO_DETECT_EN
    logic dz_r;
    assign div_by_zero = dz_r;
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            w_q       <= '0;
            w_r       <= '0;
            d         <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIVZERO_DETECT_EN
            dz_r      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
`ifdef DIVZERO_DETECT_EN
                        if (divisor == '0) begin
                            state     <= DONE;
                            busy      <= 1'b1;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend;
                            dz_r      <= 1'b1;
                        end else
`endif
                        begin
                            state <= RUN;
                            busy  <= 1'b1;
                            w_q   <= dividend;
                            w_r   <= '0;
                            d     <= divisor;
                            cnt   <= '0;
                        end
                    end
                end
                RUN: begin
                    w_q <= nq;
                    w_r <= nr;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        quotient  <= nq;
                        remainder <= nr[N-1:0];
`ifdef DIVZERO_DETECT_EN
                        dz_r      <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider_4bit.sv
// Directed self-checking bench for restoring_divider_4bit.
// Divide-by-zero expectations follow DIVZERO_DETECT_EN.
module tb_restoring_divider_4bit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    restoring_divider_4bit #(.N(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Returns extra cycles until done is seen; 20 means timed out
    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 20) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
                fails++;
                $display("FAIL reset_idle cyc%0d: got b=%b d=%b q=%0d r=%0d z=%b, need all 0",
                         i, busy, done, quotient, remainder, div_by_zero);
            end
        end
    endtask

    task automatic test_basic();
        int k;
        dividend = 4'd13;
        divisor = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_busy: got %b, need 1", busy);
        end
        wait_done(k);
        tests++;
        if (k !== 4) begin
            fails++;
            $display("FAIL basic_latency: got %0d, need 4", k);
        end
        tests++;
        if (quotient !== 4'd4 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL basic_result: got q=%0d r=%0d z=%b, need q=4 r=1 z=0",
                     quotient, remainder, div_by_zero);
        end
        tick();
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL basic_pulse: done got %b, need 0", done);
        end
        for (int i = 0; i < 5; i++) tick();
        tests++;
        if (quotient !== 4'd4 || remainder !== 4'd1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL basic_hold: got q=%0d r=%0d b=%b d=%b, need q=4 r=1 b=0 d=0",
                     quotient, remainder, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a[3] = '{4'd15, 4'd2, 4'd15};
        logic [3:0] b[3] = '{4'd1, 4'd7, 4'd15};
        logic [3:0] eq[3] = '{4'd15, 4'd0, 4'd1};
        logic [3:0] er[3] = '{4'd0, 4'd2, 4'd0};
        int k;
        int prev;
        prev = 0;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dividend = a[i];
            divisor = b[i];
            if (i > 0) tick();
            wait_done(k);
            tests++;
            if (quotient !== eq[i] || remainder !== er[i] || k >= 20) begin
                fails++;
                $display("FAIL b2b_result%0d: got q=%0d r=%0d, need q=%0d r=%0d",
                         i, quotient, remainder, eq[i], er[i]);
            end
            if (i > 0) begin
                tests++;
                if (cyc - prev !== 6) begin
                    fails++;
                    $display("FAIL b2b_period%0d: got %0d, need 6", i, cyc - prev);
                end
            end
            prev = cyc;
        end
        start = 1'b0;
        tick();
        tick();
        tick();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: busy got %b, need 0", busy);
        end
    endtask

    task automatic test_divzero();
        int k;
        int lat;
        logic z;
`ifdef DIVZERO_DETECT_EN
        lat = 0;
        z = 1'b1;
`else
        lat = 4;
        z = 1'b0;
`endif
        dividend = 4'd9;
        divisor = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(k);
        tests++;
        if (k !== lat) begin
            fails++;
            $display("FAIL divzero_latency: got %0d, need %0d", k, lat);
        end
        tests++;
        if (quotient !== 4'd15 || remainder !== 4'd9 || div_by_zero !== z) begin
            fails++;
            $display("FAIL divzero_result: got q=%0d r=%0d z=%b, need q=15 r=9 z=%b",
                     quotient, remainder, div_by_zero, z);
        end
        tick();
        tick();
    endtask

    task automatic test_ignore_start();
        int pulses;
        dividend = 4'd13;
        divisor = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        dividend = 4'd6;
        divisor = 4'd2;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) pulses++;
        end
        tests++;
        if (pulses !== 1) begin
            fails++;
            $display("FAIL ignore_pulses: got %0d, need 1", pulses);
        end
        tests++;
        if (quotient !== 4'd4 || remainder !== 4'd1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL ignore_result: got q=%0d r=%0d b=%b, need q=4 r=1 b=0",
                     quotient, remainder, busy);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        int k;
        dividend = 4'd13;
        divisor = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
            fails++;
            $display("FAIL midrst_clear: got b=%b d=%b q=%0d r=%0d z=%b, need all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        tests++;
        if (pulses !== 0) begin
            fails++;
            $display("FAIL midrst_quiet: got %0d active cycles, need 0", pulses);
        end
        dividend = 4'd7;
        divisor = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(k);
        tests++;
        if (k !== 4 || quotient !== 4'd3 || remainder !== 4'd1) begin
            fails++;
            $display("FAIL midrst_after: got k=%0d q=%0d r=%0d, need k=4 q=3 r=1",
                     k, quotient, remainder);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_divzero();
        test_ignore_start();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
